// File: rtl/sad_min_tracker.sv
// Streaming minimum-SAD selector. Each input beat carries LANES candidate SADs.
// Stage S1 reduces a beat to its smallest unmasked lane. Stage S2 folds that
// per-beat winner into a running best over a search framed by first/last. The
// result holds until downstream accepts it.
module sad_min_tracker #(
    parameter int SAD_W = 14,
    parameter int LANES = 5,
    parameter int IDX_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic [LANES*SAD_W-1:0] in_sad_vec,
    input  logic [LANES-1:0]       in_lane_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAD_W-1:0]       out_sad,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_none,
    output logic                   out_ovf
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    // beat_num is one bit wider than the index and saturates, so an
    // overflowing index is still detected however long the search runs.
    localparam int BN_W   = IDX_W + 1;
    localparam int CAND_W = 2 * IDX_W + 2;

    // S1 pipeline register: per-beat winner
    logic              s1_valid;
    logic [SAD_W-1:0]  s1_min;
    logic [LANE_W-1:0] s1_lane;
    logic              s1_any;
    logic              s1_first;
    logic              s1_last;
    logic [BN_W-1:0]   s1_beat;
    logic [BN_W-1:0]   beat_num;

    // S2 running best of the current search
    logic              acc_valid;
    logic [SAD_W-1:0]  acc_sad;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_any;
    logic              acc_ovf;

    logic              stall;
    logic              accept;
    logic              fold;

    logic [SAD_W-1:0]  red_min;
    logic [LANE_W-1:0] red_lane;
    logic              red_any;

    logic [CAND_W-1:0] cand;
    logic              cand_ovf;
    logic [SAD_W-1:0]  new_sad;
    logic [IDX_W-1:0]  new_idx;
    logic              new_any;
    logic              new_ovf;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !s1_valid || !stall;
    assign accept   = in_valid && in_ready;
    assign fold     = s1_valid && !stall;

    assign cand     = CAND_W'(s1_beat) * CAND_W'(LANES) + CAND_W'(s1_lane);
    assign cand_ovf = |cand[CAND_W-1:IDX_W];

    // Beat reduce: smallest unmasked lane, strict compare keeps the lowest lane on ties.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        red_min  = '1;
        red_lane = '0;
        red_any  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            if (in_lane_mask[k] && (!red_any || in_sad_vec[k*SAD_W +: SAD_W] < red_min)) begin
                red_min  = in_sad_vec[k*SAD_W +: SAD_W];
                red_lane = LANE_W'(k);
                red_any  = 1'b1;
            end
        end
    end

    // Fold: a first beat or an empty accumulator replaces the best; otherwise strict improvement only.
    always_comb begin
        new_sad = acc_sad;
        new_idx = acc_idx;
        new_any = acc_any;
        new_ovf = acc_ovf || (s1_any && cand_ovf);
        if (s1_first || !acc_valid) begin
            new_sad = s1_min;
            new_idx = s1_any ? cand[IDX_W-1:0] : '0;
            new_any = s1_any;
            new_ovf = s1_any && cand_ovf;
        end else if (s1_any && (!acc_any || s1_min < acc_sad)) begin
            new_sad = s1_min;
            new_idx = cand[IDX_W-1:0];
            new_any = 1'b1;
        end
    end

    // S1 register and beat counter: load on handshake, hold while stalled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_valid <= 1'b0;
            s1_min   <= '0;
            s1_lane  <= '0;
            s1_any   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_beat  <= '0;
            beat_num <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_min   <= red_min;
            s1_lane  <= red_lane;
            s1_any   <= red_any;
            s1_first <= in_first;
            s1_last  <= in_last;
            if (in_first) begin
                s1_beat  <= '0;
                beat_num <= in_last ? '0 : BN_W'(1);
            end else begin
                s1_beat  <= beat_num;
                beat_num <= in_last ? '0 :
                            (beat_num == '1) ? beat_num : beat_num + 1'b1;
            end
        end else if (!stall) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 accumulator and result registers: the last beat's fold publishes and empties the accumulator.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are reset too, so outputs read 0 straight after reset.
        if (rst) begin
            acc_valid <= 1'b0;
            acc_sad   <= '0;
            acc_idx   <= '0;
            acc_any   <= 1'b0;
            acc_ovf   <= 1'b0;
            out_valid <= 1'b0;
            out_sad   <= '0;
            out_index <= '0;
            out_none  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            if (fold && s1_last) begin
                acc_valid <= 1'b0;
                acc_any   <= 1'b0;
                acc_ovf   <= 1'b0;
                out_valid <= 1'b1;
                out_sad   <= new_sad;
                out_index <= new_idx;
                out_none  <= !new_any;
                out_ovf   <= new_ovf;
            end else begin
                if (fold) begin
                    acc_valid <= 1'b1;
                    acc_sad   <= new_sad;
                    acc_idx   <= new_idx;
                    acc_any   <= new_any;
                    acc_ovf   <= new_ovf;
                end
                if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sad_min_tracker.sv
// Self-checking bench for sad_min_tracker (SAD_W=14, LANES=5, IDX_W=4).
// A search-level reference model predicts each result from the beats sent.
module tb_sad_min_tracker;

    localparam int SAD_W = 14;
    localparam int LANES = 5;
    localparam int IDX_W = 4;
    localparam logic [SAD_W-1:0] ALL_ONES = '1;

    typedef struct {
        logic [LANES*SAD_W-1:0] vec;
        logic [LANES-1:0]       mask;
    } beat_t;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [IDX_W-1:0] idx;
        logic             none;
        logic             ovf;
    } result_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_first;
    logic                   in_last;
    logic [LANES*SAD_W-1:0] in_sad_vec;
    logic [LANES-1:0]       in_lane_mask;
    logic                   out_valid;
    logic                   out_ready;
    logic [SAD_W-1:0]       out_sad;
    logic [IDX_W-1:0]       out_index;
    logic                   out_none;
    logic                   out_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    result_t got_q[$];

    sad_min_tracker #(.SAD_W(SAD_W), .LANES(LANES), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last),
        .in_sad_vec(in_sad_vec), .in_lane_mask(in_lane_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sad(out_sad), .out_index(out_index),
        .out_none(out_none), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // Capture every accepted result; the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready)
            got_q.push_back('{out_sad, out_index, out_none, out_ovf});
    end

    function automatic beat_t mk(int a, int b, int c, int d, int e, logic [LANES-1:0] m);
        beat_t bt;
        bt.vec  = {SAD_W'(e), SAD_W'(d), SAD_W'(c), SAD_W'(b), SAD_W'(a)};
        bt.mask = m;
        return bt;
    endfunction

    // Reference: scan all candidates in global order; a beat's winner index flags overflow.
    function automatic result_t model(beat_t bs[$]);
        result_t r;
        int best = 0;
        int best_idx = 0;
        bit any = 0;
        bit ovf = 0;
        for (int b = 0; b < bs.size(); b++) begin
            int bmin = 1 << 30;
            int bl = -1;
            for (int k = 0; k < LANES; k++) begin
                int s = int'(bs[b].vec[k*SAD_W +: SAD_W]);
                if (bs[b].mask[k] && s < bmin) begin
                    bmin = s;
                    bl = k;
                end
            end
            if (bl >= 0) begin
                int gi = b * LANES + bl;
                if (gi >= (1 << IDX_W)) ovf = 1;
                if (!any || bmin < best) begin
                    best = bmin;
                    best_idx = gi;
                    any = 1;
                end
            end
        end
        r.sad  = any ? SAD_W'(best) : ALL_ONES;
        r.idx  = any ? IDX_W'(best_idx % (1 << IDX_W)) : '0;
        r.none = !any;
        r.ovf  = ovf;
        return r;
    endfunction

    task automatic drive_beat(input beat_t bt, input logic f, input logic l);
        bit ok;
        int cyc = 0;
        in_valid     = 1'b1;
        in_first     = f;
        in_last      = l;
        in_sad_vec   = bt.vec;
        in_lane_mask = bt.mask;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end while (!ok && cyc < 500);
        if (!ok) begin
            n_checks++;
            $display("FAIL drive_timeout: in_ready stayed %0b, required 1 within 500 cycles", in_ready);
        end
    endtask

    task automatic send_search(input beat_t bs[$], input bit with_last);
        for (int i = 0; i < bs.size(); i++)
            drive_beat(bs[i], i == 0, with_last && (i == bs.size() - 1));
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string name);
        int cyc = 0;
        while (got_q.size() < n && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (got_q.size() < n) begin
            n_checks++;
            $display("FAIL %s_count: got %0d results, required %0d", name, got_q.size(), n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_sad_vec = '0; in_lane_mask = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({out_valid, out_sad, out_index, out_none, out_ovf, in_ready} !== {1'b0, 14'd0, 4'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_state: valid=%0b sad=%0d idx=%0d none=%0b ovf=%0b rdy=%0b, required 0/0/0/0/0/1",
                     out_valid, out_sad, out_index, out_none, out_ovf, in_ready);
        else n_pass++;
    endtask

    task automatic test_single_latency;
        beat_t bt = mk(100, 40, 70, 40, 90, 5'b11111);
        got_q.delete();
        drive_beat(bt, 1'b1, 1'b1);
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL single_early: out_valid=%0b, required 0", out_valid);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_sad, out_index, out_none, out_ovf} !== {1'b1, 14'd40, 4'd1, 1'b0, 1'b0})
            $display("FAIL single_result: valid=%0b sad=%0d idx=%0d none=%0b ovf=%0b, required 1/40/1/0/0",
                     out_valid, out_sad, out_index, out_none, out_ovf);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL single_drop: out_valid=%0b after accept, required 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_directed;
        beat_t s[$];
        result_t exp_q[$];
        result_t g;
        beat_t lastlane[$];
        beat_t multi[$];
        beat_t tie[$];
        beat_t masked[$];
        lastlane = '{mk(50, 60, 70, 80, 10, 5'b11111)};
        multi = '{mk(30, 30, 30, 30, 30, 5'b11111), mk(30, 20, 99, 99, 99, 5'b11101),
                  mk(25, 25, 12, 25, 25, 5'b11111)};
        tie = '{mk(30, 30, 30, 30, 30, 5'b11111), mk(30, 20, 99, 99, 99, 5'b11101),
                mk(35, 35, 30, 35, 35, 5'b11111)};
        masked = '{mk(1, 2, 3, 4, 5, 5'b00000), mk(6, 7, 8, 9, 10, 5'b00000)};
        got_q.delete();
        send_search(lastlane, 1'b1); exp_q.push_back(model(lastlane));
        send_search(multi, 1'b1);    exp_q.push_back(model(multi));
        send_search(tie, 1'b1);      exp_q.push_back(model(tie));
        send_search(masked, 1'b1);   exp_q.push_back(model(masked));
        wait_results(4, "directed");
        // Hand-derived anchors alongside the model predictions.
        n_checks++;
        if (exp_q[1] !== result_t'({14'd12, 4'd12, 1'b0, 1'b0}) || exp_q[2].idx !== 4'd0 ||
            exp_q[3] !== result_t'({14'd16383, 4'd0, 1'b1, 1'b0}))
            $display("FAIL directed_model: model disagrees with hand-derived results");
        else n_pass++;
        for (int i = 0; i < 4 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            n_checks++;
            if (g !== exp_q[i])
                $display("FAIL directed_%0d: sad=%0d idx=%0d none=%0b ovf=%0b, required sad=%0d idx=%0d none=%0b ovf=%0b",
                         i, g.sad, g.idx, g.none, g.ovf, exp_q[i].sad, exp_q[i].idx, exp_q[i].none, exp_q[i].ovf);
            else n_pass++;
        end
    endtask

    task automatic test_overflow;
        beat_t a[$];
        beat_t b[$];
        result_t g;
        a = '{mk(100, 100, 100, 100, 100, 5'b11111), mk(100, 100, 100, 100, 100, 5'b11111),
              mk(100, 100, 100, 100, 100, 5'b11111), mk(1, 100, 100, 100, 100, 5'b11111)};
        b = '{mk(100, 100, 100, 100, 100, 5'b11111), mk(100, 100, 100, 100, 100, 5'b11111),
              mk(100, 100, 100, 100, 100, 5'b11111), mk(100, 1, 100, 100, 100, 5'b11111)};
        got_q.delete();
        send_search(a, 1'b1);
        send_search(b, 1'b1);
        wait_results(2, "overflow");
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_checks++;
            if ({g.sad, g.idx, g.ovf} !== {14'd1, 4'd15, 1'b0})
                $display("FAIL ovf_idx15: sad=%0d idx=%0d ovf=%0b, required 1/15/0", g.sad, g.idx, g.ovf);
            else n_pass++;
        end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_checks++;
            if ({g.sad, g.idx, g.ovf} !== {14'd1, 4'd0, 1'b1})
                $display("FAIL ovf_idx16: sad=%0d idx=%0d ovf=%0b, required 1/0/1", g.sad, g.idx, g.ovf);
            else n_pass++;
        end
    endtask

    task automatic test_framing;
        beat_t partial[$];
        beat_t full[$];
        result_t g;
        partial = '{mk(5, 5, 5, 5, 5, 5'b11111), mk(6, 6, 6, 6, 6, 5'b11111)};
        full = '{mk(50, 44, 60, 70, 80, 5'b11111)};
        got_q.delete();
        send_search(partial, 1'b0);
        send_search(full, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != 1) $display("FAIL framing_count: got %0d results, required 1", got_q.size());
        else n_pass++;
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_checks++;
            if ({g.sad, g.idx, g.none} !== {14'd44, 4'd1, 1'b0})
                $display("FAIL framing_result: sad=%0d idx=%0d none=%0b, required 44/1/0", g.sad, g.idx, g.none);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        beat_t a[$];
        beat_t b[$];
        result_t snap;
        result_t g;
        result_t ea;
        result_t eb;
        bit stable = 1;
        bit saw_drop = 0;
        int cyc = 0;
        a = '{mk(9, 8, 7, 6, 5, 5'b01111), mk(3, 9, 9, 9, 9, 5'b11111)};
        b = '{mk(20, 21, 22, 23, 24, 5'b11111), mk(19, 2, 30, 30, 30, 5'b11110),
              mk(11, 12, 13, 14, 15, 5'b11111)};
        ea = model(a);
        eb = model(b);
        got_q.delete();
        out_ready = 1'b0;
        fork
            begin
                send_search(a, 1'b1);
                send_search(b, 1'b1);
            end
            begin
                while (!out_valid && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                end
                snap = '{out_sad, out_index, out_none, out_ovf};
                repeat (5) begin
                    @(negedge clk);
                    if (!out_valid || result_t'({out_sad, out_index, out_none, out_ovf}) !== snap) stable = 0;
                    if (!in_ready) saw_drop = 1;
                end
                n_checks++;
                if (!stable || snap !== ea)
                    $display("FAIL bp_stable: stable=%0b held sad=%0d idx=%0d, required stable=1 sad=%0d idx=%0d",
                             stable, snap.sad, snap.idx, ea.sad, ea.idx);
                else n_pass++;
                n_checks++;
                if (!saw_drop) $display("FAIL bp_ready_drop: in_ready never 0, required 0 while S1 full");
                else n_pass++;
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_results(2, "bp");
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_checks++;
            if (g !== ea) $display("FAIL bp_first: sad=%0d idx=%0d, required sad=%0d idx=%0d", g.sad, g.idx, ea.sad, ea.idx);
            else n_pass++;
        end
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_checks++;
            if (g !== eb) $display("FAIL bp_second: sad=%0d idx=%0d, required sad=%0d idx=%0d", g.sad, g.idx, eb.sad, eb.idx);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        result_t exp_q[$];
        result_t g;
        bit done = 0;
        int n = 30;
        fork
            begin
                for (int s = 0; s < n; s++) begin
                    beat_t bs[$];
                    int nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++) begin
                        beat_t bt;
                        for (int k = 0; k < LANES; k++)
                            bt.vec[k*SAD_W +: SAD_W] = ($urandom_range(0, 9) == 0) ? ALL_ONES
                                                       : SAD_W'($urandom_range(0, 40));
                        bt.mask = ($urandom_range(0, 5) == 0) ? 5'b00000 : 5'($urandom_range(0, 31));
                        bs.push_back(bt);
                    end
                    exp_q.push_back(model(bs));
                    send_search(bs, 1'b1);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_results(n, "random");
        for (int i = 0; i < n && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            n_checks++;
            if (g !== exp_q[i])
                $display("FAIL random_%0d: sad=%0d idx=%0d none=%0b ovf=%0b, required sad=%0d idx=%0d none=%0b ovf=%0b",
                         i, g.sad, g.idx, g.none, g.ovf, exp_q[i].sad, exp_q[i].idx, exp_q[i].none, exp_q[i].ovf);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        beat_t one[$];
        beat_t part[$];
        beat_t after[$];
        result_t g;
        one = '{mk(7, 8, 9, 10, 11, 5'b11111)};
        part = '{mk(1, 1, 1, 1, 1, 5'b11111)};
        after = '{mk(60, 61, 62, 33, 64, 5'b11111)};
        got_q.delete();
        out_ready = 1'b0;
        send_search(one, 1'b1);
        send_search(part, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, out_sad, out_index, out_none, out_ovf, in_ready} !== {1'b0, 14'd0, 4'd0, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_mid: valid=%0b sad=%0d idx=%0d none=%0b ovf=%0b rdy=%0b, required 0/0/0/0/0/1",
                     out_valid, out_sad, out_index, out_none, out_ovf, in_ready);
        else n_pass++;
        rst = 1'b0;
        out_ready = 1'b1;
        got_q.delete();
        send_search(after, 1'b1);
        wait_results(1, "post_reset");
        if (got_q.size() > 0) begin
            g = got_q.pop_front();
            n_checks++;
            if ({g.sad, g.idx, g.none, g.ovf} !== {14'd33, 4'd3, 1'b0, 1'b0})
                $display("FAIL post_reset: sad=%0d idx=%0d none=%0b ovf=%0b, required 33/3/0/0", g.sad, g.idx, g.none, g.ovf);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_single_latency;
        test_directed;
        test_overflow;
        test_framing;
        test_backpressure;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sad_min_tracker.md
Name: sad_min_tracker

Overview:
- Streaming, pipelined minimum-SAD selector for the motion-estimation search.
- Accepts LANES candidate SADs per beat over a multi-beat search window framed by first/last.
- Keeps a running best and returns the smallest SAD with its global candidate index.
- Sits between the SAD array and the motion-vector decision logic, and generalises the single-beat 5-candidate combinational minimum to arbitrary lane count, widths and search length.

Parameters:
SAD_W, 14, width of one SAD value
LANES, 5, candidate SADs per input beat (>=1)
IDX_W, 10, width of global candidate index, must satisfy 2^IDX_W >= LANES

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_first  in  1  beat is first of a search
in_last  in  1  beat is last of a search
in_sad_vec  in  LANES*SAD_W  lane k at bits [k*SAD_W +: SAD_W]
in_lane_mask  in  LANES  1 = lane k participates
out_valid  out  1  result valid, held until accepted
out_ready  in  1  downstream accept
out_sad  out  SAD_W  smallest SAD of the search
out_index  out  IDX_W  global index of the winner = beat_num*LANES + lane
out_none  out  1  no unmasked lane in the whole search
out_ovf  out  1  a candidate index exceeded 2^IDX_W-1 during the search

Behaviour:
- Reset: clk and rst are the single clock and its synchronous active-high reset. On rst all registers clear. out_valid=0, out_sad=0, out_index=0, out_none=0, out_ovf=0, in_ready=1, S1 empty, accumulator empty, beat_num=0.
- Stage S1, beat reduce: registered min over the unmasked lanes.
  - Ties go to the lowest lane.
  - Registers beat_min, lane, any_valid, first, last and beat_num.
  - Fully masked beat: any_valid=0 and beat_min=all ones.
- Stage S2, accumulate: when S1 is valid and not stalled, fold S1 into the running best.
  - If the S1 beat has first set, or the accumulator is empty, the running best is replaced by the S1 beat rather than compared against it.
  - A beat replaces the running best only if any_valid && beat_min < best (strict compare). Ties keep the earlier candidate, so the lowest global index wins.
- beat_num: increments per accepted beat and clears on an accepted first beat and after an accepted last beat.
  - Candidate index is computed IDX_W+1 wide. Values >= 2^IDX_W set sticky ovf for the search; the reported index is then the low IDX_W bits.
- Result: when the S1 beat carrying last folds, the result registers drive out_* and out_valid=1 on the next cycle.
  - Latency from the last-beat handshake to out_valid is 2 cycles.
  - Accumulator and ovf clear in the same fold.
  - out_none=1 when no beat of the search had any_valid. In that case out_sad=all ones and out_index=0.
- Stall and in_ready:
  - stall = out_valid && !out_ready.
  - S1 does not advance while stall is true.
  - in_ready = !S1_valid || !stall.
  - out_* are stable while stall is true.
  - out_valid drops the cycle after the out_valid && out_ready handshake, unless a new result registers on that same edge.
- Back-to-back searches: a first beat may be accepted the cycle after a last beat, giving full throughput of one beat per cycle with no bubbles.
- Framing errors:
  - A first beat mid-search discards the partial search silently, with no output.
  - in_first && in_last marks a single-beat search.
- Reset mid-search discards everything, including a pending unaccepted result.
- in_sad_vec, in_lane_mask, in_first and in_last are sampled only on the in_valid && in_ready handshake.

Test Plan:
- Single beat, LANES=5, SADs {100,40,70,40,90}, mask 11111, first=last=1 -> 2 cycles later out_sad=40, out_index=1, out_none=0.
- Last-lane winner: SADs {50,60,70,80,10}, single beat -> out_sad=10, out_index=4.
- Multi-beat, 3 beats:
  - beat0 {30,30,30,30,30}, beat1 {30,20,99,99,99} with lane1 masked, beat2 {25,25,12,25,25}.
  - Required result: out_sad=12, out_index=12.
  - Repeat with beat2 lane2=30 -> out_sad=30, out_index=0 (tie keeps the earliest candidate).
- All lanes masked for a 2-beat search -> out_none=1, out_sad=16383, out_index=0.
- Backpressure: hold out_ready=0 for 5 cycles while streaming a second search.
  - out_* must stay stable and in_ready must drop once S1 is full.
  - After release, both results arrive in order with no lost beat.
- Overflow and reset:
  - IDX_W=4, LANES=5, 4 beats with the minimum in beat3 lane0 (index 15) -> out_ovf=0.
  - Minimum in beat3 lane1 (index 16) -> out_ovf=1, out_index=0.
  - Asserting rst mid-search then clears all outputs to 0 on the next cycle.
